// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared definitions for the multi-cycle hazard unit.
//   - Forwarding select encodings driven onto ForwardAE / ForwardBE.
//   - State type for the MDU occupancy state machine.
package hazard_pkg;

    // Forwarding mux selects for the E-stage operand muxes
    localparam logic [1:0] FWD_RF = 2'b00;  // value read from the register file
    localparam logic [1:0] FWD_W  = 2'b01;  // result being written back in W
    localparam logic [1:0] FWD_M  = 2'b10;  // ALU result sitting in M

    // MDU occupancy: IDLE while no multi-cycle op holds E, BUSY while one does
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt
// Saturating performance counter.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-low reset (clears the count)
//   inc   - add one this cycle (ignored once the count is all-ones)
//   clr   - synchronous clear, takes priority over inc
//   cnt   - current count
module hazard_perf_cnt #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              clr,
    output logic [PERF_W-1:0] cnt
);

    logic [PERF_W-1:0] cnt_d;
    logic [PERF_W-1:0] cnt_q;

    // Next count: clear beats increment, and the count sticks at all-ones
    // so a long-running measurement never wraps back to a small value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc
// Hazard unit for the RV32 five-stage pipeline whose execute stage also hosts
// a multi-cycle multiply/divide unit (MDU).
// Ports:
//   clk, reset               - clock, synchronous active-low reset
//   Rs1D, Rs2D               - D-stage source registers
//   Rs1E, Rs2E, RdE          - E-stage sources / destination
//   RdM, RdW                 - M / W destinations
//   RegWriteM, RegWriteW     - register write enables in M / W
//   ResultSrcb0E             - E holds a load
//   PCSrcE                   - taken branch/jump in E
//   MduStartE, MduDoneE      - E holds an MDU op / MDU result valid this cycle
//   PerfClr                  - synchronous clear of the performance counters
//   ForwardAE, ForwardBE     - operand forwarding selects (combinational)
//   StallF/D/E, FlushD/E/M   - pipeline register hold / bubble controls (combinational)
//   MduBusy, MduErr          - MDU state machine in BUSY / sticky watchdog abort (registered)
//   StallCnt, FlushCnt       - saturating stall / flush cycle counters (registered)
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int MDU_TIMEOUT = 64,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              ResultSrcb0E,
    input  logic              PCSrcE,
    input  logic              MduStartE,
    input  logic              MduDoneE,
    input  logic              PerfClr,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              MduBusy,
    output logic              MduErr,
    output logic [PERF_W-1:0] StallCnt,
    output logic [PERF_W-1:0] FlushCnt
);

    // Watchdog counts BUSY cycles; it never needs to exceed MDU_TIMEOUT-1.
    localparam int WD_W = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MDU_TIMEOUT - 1);

    mdu_state_e      state_d, state_q;
    logic [WD_W-1:0] wd_cnt_d, wd_cnt_q;
    logic            mdu_err_d, mdu_err_q;

    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       lw_stall;
    logic       mdu_stall;
    logic       timeout;

    // Forwarding: the younger M result wins over W, and x0 is never forwarded
    // because its architectural value is always zero.
    always_comb begin
        fwd_a = FWD_RF;
        if (RegWriteM && (RdM == Rs1E) && (Rs1E != '0)) begin
            fwd_a = FWD_M;
        end else if (RegWriteW && (RdW == Rs1E) && (Rs1E != '0)) begin
            fwd_a = FWD_W;
        end

        fwd_b = FWD_RF;
        if (RegWriteM && (RdM == Rs2E) && (Rs2E != '0)) begin
            fwd_b = FWD_M;
        end else if (RegWriteW && (RdW == Rs2E) && (Rs2E != '0)) begin
            fwd_b = FWD_W;
        end
    end

    // Load-use: the load's data is not available until M, so a dependent
    // instruction in D must wait one cycle.
    assign lw_stall = ResultSrcb0E && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

    // MDU occupancy FSM. The stall is dropped in the cycle the result arrives
    // (or the watchdog fires) so the MDU instruction advances to M that cycle.
    // A start with the result already valid is a zero-latency op and never stalls.
    always_comb begin
        state_d   = state_q;
        wd_cnt_d  = wd_cnt_q;
        mdu_err_d = mdu_err_q;
        timeout   = 1'b0;
        mdu_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (MduStartE && !MduDoneE) begin
                    mdu_stall = 1'b1;
                    state_d   = BUSY;
                    wd_cnt_d  = '0;
                end
            end
            BUSY: begin
                timeout = (wd_cnt_q == WD_LAST) && !MduDoneE;
                if (MduDoneE) begin
                    state_d = IDLE;
                end else if (timeout) begin
                    state_d   = IDLE;
                    mdu_err_d = 1'b1;
                end else begin
                    mdu_stall = 1'b1;
                    wd_cnt_d  = wd_cnt_q + WD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            wd_cnt_q  <= '0;
            mdu_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_cnt_q  <= wd_cnt_d;
            mdu_err_q <= mdu_err_d;
        end
    end

    // While the MDU holds E, the whole front end freezes and M gets bubbles;
    // any branch flush is deferred until E is released.
    assign ForwardAE = fwd_a;
    assign ForwardBE = fwd_b;
    assign StallF    = lw_stall || mdu_stall;
    assign StallD    = lw_stall || mdu_stall;
    assign StallE    = mdu_stall;
    assign FlushM    = mdu_stall;
    assign FlushD    = PCSrcE && !mdu_stall;
    assign FlushE    = (lw_stall || PCSrcE) && !mdu_stall;
    assign MduBusy   = (state_q == BUSY);
    assign MduErr    = mdu_err_q;

    hazard_perf_cnt #(
        .PERF_W (PERF_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (StallF),
        .clr   (PerfClr),
        .cnt   (StallCnt)
    );

    // Only branch-induced flushes count; load-use bubbles are already in StallCnt.
    hazard_perf_cnt #(
        .PERF_W (PERF_W)
    ) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (PCSrcE && FlushE),
        .clr   (PerfClr),
        .cnt   (FlushCnt)
    );

endmodule
